// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter feeding COUNT valid/ready streams into one registered output stage.
// Define ARB_PACKET_LOCK_EN to hold the grant on one input from its first beat until its s_last beat.
module stream_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned COUNT = 4,
    localparam int unsigned IDW  = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [COUNT-1:0]       s_valid,
    output logic [COUNT-1:0]       s_ready,
    input  logic [COUNT*WIDTH-1:0] s_data,
    input  logic [COUNT-1:0]       s_last,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_last,
    output logic [IDW-1:0]         m_id
);

    localparam logic [IDW-1:0] PTR_RESET = IDW'(COUNT - 1);

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             m_last_q,  m_last_d;
    logic [IDW-1:0]   m_id_q,    m_id_d;
    logic [IDW-1:0]   ptr_q,     ptr_d;

    logic [IDW-1:0]   rr_sel, cand, sel;
    logic             rr_ok, sel_ok;
    logic             load, accept;
    int unsigned      idx;

`ifdef ARB_PACKET_LOCK_EN
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;
    state_t           state_q, state_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
`endif

    // Round-robin search starting just after the last granted input.
    always_comb begin
        rr_sel = '0;
        rr_ok  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int unsigned k = 1; k <= COUNT; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= COUNT) begin
                idx = idx - COUNT;
            end
            cand = IDW'(idx);
            if (!rr_ok && s_valid[cand]) begin
                rr_ok  = 1'b1;
                rr_sel = cand;
            end
        end
    end

`ifdef ARB_PACKET_LOCK_EN
    always_comb begin
        if (state_q == LOCK) begin
            sel    = lock_id_q;
            sel_ok = s_valid[lock_id_q];
        end else begin
            sel    = rr_sel;
            sel_ok = rr_ok;
        end
    end
`else
    assign sel    = rr_sel;
    assign sel_ok = rr_ok;
`endif

    // Gated by reset_n so no input sees ready while the output stage is held in reset.
    assign load   = reset_n & (~m_valid_q | m_ready);
    assign accept = sel_ok & load;

    always_comb begin
        s_ready = '0;
        if (accept) begin
            s_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        m_id_d    = m_id_q;
        ptr_d     = ptr_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = s_data[32'(sel) * WIDTH +: WIDTH];
            m_last_d  = s_last[sel];
            m_id_d    = sel;
            ptr_d     = sel;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

`ifdef ARB_PACKET_LOCK_EN
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    if (!s_last[sel]) begin
                        state_d   = LOCK;
                        lock_id_d = sel;
                    end
                end
                LOCK: begin
                    if (s_last[sel]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_id_q    <= '0;
            ptr_q     <= PTR_RESET;
`ifdef ARB_PACKET_LOCK_EN
            state_q   <= IDLE;
            lock_id_q <= '0;
`endif
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            m_id_q    <= m_id_d;
            ptr_q     <= ptr_d;
`ifdef ARB_PACKET_LOCK_EN
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
`endif
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign m_id    = m_id_q;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk) $onehot0(s_ready));
    a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last) && $stable(m_id)));
`endif

endmodule
